// File: rtl/freqdetect_topk.sv
// Top-K spectral peak detector: after each FFT frame, scans a bin window of the FFT RAM and
// keeps a sorted list of the strongest L1-magnitude bins above a programmable threshold.
module freqdetect_topk #(
    parameter int DATA_W = 28,
    parameter int ADDR_W = 10,
    parameter int TOPK   = 4,
    parameter int BIN_LO = 1,
    parameter int BIN_HI = 511,
    parameter int RD_LAT = 1,
    localparam int MAG_W = DATA_W/2 + 1,
    localparam int NPK_W = $clog2(TOPK+1)
) (
    input  logic                   clk,
    input  logic [3:0]             KEY,
    input  logic                   fftdone,
    input  logic [MAG_W-1:0]       thresh,
    input  logic [DATA_W-1:0]      ramq,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic                   busy,
    output logic                   detectdone,
    output logic [ADDR_W-1:0]      maxbin,
    output logic [TOPK*ADDR_W-1:0] peakbins,
    output logic [TOPK*MAG_W-1:0]  peakmags,
    output logic [NPK_W-1:0]       npeaks
);
    localparam int HALF_W = DATA_W/2;
    localparam int DCNT_W = $clog2(RD_LAT+2);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    logic rst_n;
    logic unused_key;
    assign rst_n      = KEY[0];
    assign unused_key = &{1'b0, KEY[3:1]};

    state_t            state, state_nxt;
    logic              pending, pending_nxt;
    logic              scan_start;
    logic [DCNT_W-1:0] drain_cnt;
    logic [MAG_W-1:0]  thr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // NOTE: defaults at the top of every combinational block keep all paths assigned, so no latches.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE:  if (fftdone) state_nxt = SCAN;
            SCAN: begin
                pending_nxt = pending | fftdone;
                if (ramaddr == ADDR_W'(BIN_HI)) state_nxt = DRAIN;
            end
            DRAIN: begin
                pending_nxt = pending | fftdone;
                if (drain_cnt == DCNT_W'(RD_LAT)) state_nxt = DONE;
            end
            DONE: begin
                pending_nxt = 1'b0;
                state_nxt   = (pending | fftdone) ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        detectdone = (state == DONE);
    end

    assign scan_start = (state_nxt == SCAN) && (state != SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramaddr   <= '0;
            drain_cnt <= '0;
        end else begin
            if (scan_start)
                ramaddr <= ADDR_W'(BIN_LO);
            else if (state == SCAN && ramaddr != ADDR_W'(BIN_HI))
                ramaddr <= ramaddr + ADDR_W'(1);
            drain_cnt <= (state == DRAIN) ? drain_cnt + DCNT_W'(1) : '0;
        end
    end

    // Bin index delayed to line up with the RAM read data.
    logic [ADDR_W-1:0] d_bin [RD_LAT];
    logic [RD_LAT-1:0] d_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) d_bin[i] <= '0;
        end else begin
            d_vld[0] <= (state == SCAN);
            d_bin[0] <= ramaddr;
            for (int i = 1; i < RD_LAT; i++) begin
                d_vld[i] <= d_vld[i-1];
                d_bin[i] <= d_bin[i-1];
            end
        end
    end

    // One extra bit of headroom makes |-2^(HALF_W-1)| exact.
    logic signed [MAG_W-1:0] re_x, im_x;
    logic [MAG_W-1:0]        abs_re, abs_im;
    logic                    m_vld;
    logic [ADDR_W-1:0]       m_bin;
    logic [MAG_W-1:0]        m_mag;

    assign re_x   = MAG_W'($signed(ramq[DATA_W-1:HALF_W]));
    assign im_x   = MAG_W'($signed(ramq[HALF_W-1:0]));
    assign abs_re = re_x[MAG_W-1] ? MAG_W'(-re_x) : MAG_W'(re_x);
    assign abs_im = im_x[MAG_W-1] ? MAG_W'(-im_x) : MAG_W'(im_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_bin <= '0;
            m_mag <= '0;
        end else begin
            m_vld <= d_vld[RD_LAT-1];
            m_bin <= d_bin[RD_LAT-1];
            m_mag <= abs_re + abs_im;
        end
    end

    logic [ADDR_W-1:0] l_bin [TOPK], sh_bin [TOPK], n_bin [TOPK];
    logic [MAG_W-1:0]  l_mag [TOPK], sh_mag [TOPK], n_mag [TOPK];
    logic [NPK_W-1:0]  l_cnt, n_cnt;
    logic [TOPK-1:0]   gt, gt_prev;
    logic              qual;

    // gt is monotone over the descending list; the new entry lands at its first set bit.
    always_comb begin
        qual = m_vld && (m_mag > thr_q);
        for (int r = 0; r < TOPK; r++) gt[r] = qual && (m_mag > l_mag[r]);
        gt_prev   = gt << 1;
        sh_bin[0] = '0;
        sh_mag[0] = '0;
        for (int r = 1; r < TOPK; r++) begin
            sh_bin[r] = l_bin[r-1];
            sh_mag[r] = l_mag[r-1];
        end
        for (int r = 0; r < TOPK; r++) begin
            n_bin[r] = l_bin[r];
            n_mag[r] = l_mag[r];
            if (gt[r] && !gt_prev[r]) begin
                n_bin[r] = m_bin;
                n_mag[r] = m_mag;
            end else if (gt[r]) begin
                n_bin[r] = sh_bin[r];
                n_mag[r] = sh_mag[r];
            end
        end
        n_cnt = l_cnt;
        if (gt[TOPK-1] && l_cnt != NPK_W'(TOPK)) n_cnt = l_cnt + NPK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the list arrays are reset explicitly because unused ranks must read back as zero.
            for (int r = 0; r < TOPK; r++) begin
                l_bin[r] <= '0;
                l_mag[r] <= '0;
            end
            l_cnt <= '0;
            thr_q <= '0;
        end else if (scan_start) begin
            for (int r = 0; r < TOPK; r++) begin
                l_bin[r] <= '0;
                l_mag[r] <= '0;
            end
            l_cnt <= '0;
            thr_q <= thresh;
        end else begin
            for (int r = 0; r < TOPK; r++) begin
                l_bin[r] <= n_bin[r];
                l_mag[r] <= n_mag[r];
            end
            l_cnt <= n_cnt;
        end
    end

    // Results are published on the edge entering DONE, including the final insertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxbin   <= '0;
            peakbins <= '0;
            peakmags <= '0;
            npeaks   <= '0;
        end else if (state_nxt == DONE) begin
            maxbin <= n_bin[0];
            npeaks <= n_cnt;
            for (int r = 0; r < TOPK; r++) begin
                peakbins[r*ADDR_W +: ADDR_W] <= n_bin[r];
                peakmags[r*MAG_W +: MAG_W]   <= n_mag[r];
            end
        end
    end

endmodule

// File: tb/tb_freqdetect_topk.sv
// Self-checking bench for freqdetect_topk: directed and randomized frames checked against a
// selection-based reference model of the ranked peak list.
module tb_freqdetect_topk;
    localparam int DATA_W = 28;
    localparam int ADDR_W = 10;
    localparam int TOPK   = 4;
    localparam int BIN_LO = 1;
    localparam int BIN_HI = 511;
    localparam int RD_LAT = 1;
    localparam int MAG_W  = 15;
    localparam int NPK_W  = 3;
    localparam int N      = BIN_HI - BIN_LO + 1;
    localparam int LAT    = N + RD_LAT + 2;

    logic                   clk = 1'b0;
    logic [3:0]             KEY;
    logic                   fftdone;
    logic [MAG_W-1:0]       thresh;
    logic [DATA_W-1:0]      ramq;
    logic [ADDR_W-1:0]      ramaddr;
    logic                   busy;
    logic                   detectdone;
    logic [ADDR_W-1:0]      maxbin;
    logic [TOPK*ADDR_W-1:0] peakbins;
    logic [TOPK*MAG_W-1:0]  peakmags;
    logic [NPK_W-1:0]       npeaks;

    freqdetect_topk dut (
        .clk(clk), .KEY(KEY), .fftdone(fftdone), .thresh(thresh), .ramq(ramq),
        .ramaddr(ramaddr), .busy(busy), .detectdone(detectdone), .maxbin(maxbin),
        .peakbins(peakbins), .peakmags(peakmags), .npeaks(npeaks)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) ramq <= mem[ramaddr];

    int checks = 0;
    int errors = 0;
    int exp_bin [TOPK];
    int exp_mag [TOPK];
    int exp_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] w(input int re, input int im);
        return {re[13:0], im[13:0]};
    endfunction

    function automatic int mag_of(input logic [DATA_W-1:0] word);
        int re, im;
        re = $signed(word[27:14]);
        im = $signed(word[13:0]);
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    // Rank k is the strongest not-yet-chosen bin above thr; ascending scan keeps lower bins on ties.
    task automatic model(input int thr);
        bit used [1024];
        int best, best_mag, m;
        exp_n = 0;
        for (int k = 0; k < TOPK; k++) begin
            exp_bin[k] = 0;
            exp_mag[k] = 0;
            best = -1;
            best_mag = thr;
            for (int b = BIN_LO; b <= BIN_HI; b++) begin
                m = mag_of(mem[b]);
                if (!used[b] && m > best_mag) begin
                    best = b;
                    best_mag = m;
                end
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                exp_bin[k] = best;
                exp_mag[k] = best_mag;
                exp_n++;
            end
        end
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 1024; b++) mem[b] = '0;
    endtask

    task automatic fill_random(input int span);
        int re, im;
        for (int b = 0; b < 1024; b++) begin
            if (span == 0) begin
                mem[b] = DATA_W'($urandom());
            end else begin
                re = int'($urandom_range(0, 2*span)) - span;
                im = int'($urandom_range(0, 2*span)) - span;
                mem[b] = w(re, im);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ramaddr"}, ramaddr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_detectdone"}, detectdone, 0);
        check({tag, "_maxbin"}, maxbin, 0);
        check({tag, "_npeaks"}, npeaks, 0);
        check({tag, "_peakbins"}, peakbins, 0);
        check({tag, "_peakmags"}, peakmags, 0);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_maxbin"}, maxbin, exp_bin[0]);
        check({tag, "_npeaks"}, npeaks, exp_n);
        for (int r = 0; r < TOPK; r++) begin
            check($sformatf("%s_bin%0d", tag, r), peakbins[r*ADDR_W +: ADDR_W], exp_bin[r]);
            check($sformatf("%s_mag%0d", tag, r), peakmags[r*MAG_W +: MAG_W], exp_mag[r]);
        end
    endtask

    // Called at posedge+1; fftdone is sampled on the next edge, after which cycle 1 begins.
    task automatic start_frame();
        fftdone = 1'b1;
        @(posedge clk);
        #1;
        fftdone = 1'b0;
    endtask

    // Returns the cycle index (cycle 1 = first after the start edge) where detectdone is seen.
    task automatic wait_done(input int pulse_at, output int cyc, output bit busy_ok);
        cyc = 1;
        busy_ok = 1'b1;
        while (detectdone !== 1'b1 && cyc <= 2*LAT) begin
            if (pulse_at >= 0) fftdone = (cyc == pulse_at || cyc == pulse_at + 10);
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        fftdone = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic run_frame(input int thr, input string tag);
        int cyc;
        bit bok;
        thresh = MAG_W'(thr);
        model(thr);
        start_frame();
        wait_done(-1, cyc, bok);
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_busy_during"}, bok, 1);
        check_results(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, detectdone, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int cyc;
        bit bok;
        bit seen;
        logic [TOPK*ADDR_W-1:0] exp_pk;

        KEY = 4'hF;
        fftdone = 1'b0;
        thresh = '0;
        clear_mem();
        #2 KEY = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        KEY = 4'hF;
        @(posedge clk);
        #1;

        mem[100] = w(3000, -4000);
        run_frame(100, "single");
        check("single_mag_const", peakmags[MAG_W-1:0], 7000);
        check("single_bin_const", maxbin, 100);

        clear_mem();
        mem[10] = w(500, 0);
        mem[20] = w(0, -900);
        mem[30] = w(-350, 350);
        mem[40] = w(300, 0);
        mem[50] = w(400, -400);
        run_frame(100, "five");
        exp_pk = {10'd10, 10'd30, 10'd50, 10'd20};
        check("five_packed", peakbins, exp_pk);

        clear_mem();
        mem[60] = w(600, -400);
        mem[70] = w(-1000, 0);
        mem[65] = w(0, 999);
        run_frame(100, "ties");

        fill_random(2500);
        run_frame(5000, "below");

        fill_random(0);
        mem[0] = w(-8192, -8192);
        mem[BIN_HI] = w(-8192, -8192);
        mem[BIN_HI+1] = w(-8192, -8192);
        run_frame(int'($urandom_range(9000, 15000)), "rand_full");
        check("rand_edge_mag", peakmags[MAG_W-1:0], 16384);

        fill_random(3000);
        run_frame(int'($urandom_range(0, 200)), "rand_small");

        fill_random(0);
        thresh = MAG_W'($urandom_range(8000, 14000));
        model(int'(thresh));
        start_frame();
        wait_done(50, cyc, bok);
        check("pend1_latency", cyc, LAT);
        check("pend1_busy", bok, 1);
        check_results("pend1");
        fill_random(0);
        model(int'(thresh));
        @(posedge clk);
        #1;
        wait_done(-1, cyc, bok);
        check("pend2_latency", cyc, LAT);
        check("pend2_busy", bok, 1);
        check_results("pend2");
        @(posedge clk);
        #1;
        check("pend_merged_idle", busy, 0);

        fill_random(0);
        thresh = MAG_W'(10000);
        start_frame();
        repeat (199) begin
            @(posedge clk);
            #1;
        end
        KEY = 4'h0;
        #1;
        check_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        KEY = 4'hF;
        seen = 1'b0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (detectdone === 1'b1) seen = 1'b1;
        end
        check("reset_mid_no_done", seen, 0);
        fill_random(0);
        run_frame(int'($urandom_range(9000, 14000)), "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
